// File: rtl/mem_wb_stage.sv
// Purpose : M-stage of the MIPS pipeline: data memory, M pipeline registers, W result mux.
// Latency : loads and pipeline registers 1 cycle; ResultW is combinational from the M registers.
// Backpr. : none; every cycle is accepted, with no stall, enable or handshake.
//
// Ports:
//   clk, reset (sync, active-low)      clock and reset
//   RegWriteE/SDtoRegE/MemWriteE       E-stage control
//   ALUOutE/WriteDataE/WriteRegE/PCE   E-stage data (ALUOutE is the byte address for memory)
//   RegWriteM/SDtoRegM/ALUOutM/ReadDataM/WriteRegM/PCM   registered M-stage values
//   ResultW                            write-back value selected by SDtoRegM
// Optional: define DM_TRACE_EN to print one line per accepted store.
module mem_wb_stage #(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic [1:0]  SDtoRegE,
    input  logic        MemWriteE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    input  logic [31:0] PCE,
    output logic        RegWriteM,
    output logic [1:0]  SDtoRegM,
    output logic [31:0] ALUOutM,
    output logic [31:0] ReadDataM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] PCM,
    output logic [31:0] ResultW
);

    // Power-up values are zero, matching the reset state.
    logic        regWriteQ = 1'b0;
    logic [1:0]  sdToRegQ  = 2'b00;
    logic [31:0] aluOutQ   = 32'h0;
    logic [31:0] readDataQ = 32'h0;
    logic [4:0]  writeRegQ = 5'h0;
    logic [31:0] pcQ       = 32'h0;

    logic [31:0] mem [DM_WORDS] = '{default: 32'h0};

    // Word index: byte offset is dropped (misaligned rounds down) and high bits
    // are dropped (addresses wrap modulo the memory size).
    logic [DM_AW-1:0] idx;
    assign idx = ALUOutE[DM_AW+1:2];

    logic unusedAddrBits;
    assign unusedAddrBits = ^{ALUOutE[1:0], ALUOutE[31:DM_AW+2]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            regWriteQ <= 1'b0;
            sdToRegQ  <= 2'b00;
            aluOutQ   <= 32'h0;
            readDataQ <= 32'h0;
            writeRegQ <= 5'h0;
            pcQ       <= 32'h0;
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            regWriteQ <= RegWriteE;
            sdToRegQ  <= SDtoRegE;
            aluOutQ   <= ALUOutE;
            writeRegQ <= WriteRegE;
            pcQ       <= PCE;
            // Store and load share one index, so a store always bypasses to
            // the read port (write-first).
            if (MemWriteE) begin
                mem[idx]  <= WriteDataE;
                readDataQ <= WriteDataE;
            end else begin
                readDataQ <= mem[idx];
            end
`ifdef DM_TRACE_EN
            if (MemWriteE) begin
                $display("%d@%h: *%h <= %h", $time, PCE, {ALUOutE[31:2], 2'b00}, WriteDataE);
            end
`endif
        end
    end

    assign RegWriteM = regWriteQ;
    assign SDtoRegM  = sdToRegQ;
    assign ALUOutM   = aluOutQ;
    assign ReadDataM = readDataQ;
    assign WriteRegM = writeRegQ;
    assign PCM       = pcQ;

    always_comb begin
        ResultW = 32'h0;
        case (sdToRegQ)
            2'd0:    ResultW = aluOutQ;
            2'd1:    ResultW = readDataQ;
            2'd2:    ResultW = pcQ + 32'd8;   // jal link address
            default: ResultW = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE;
    logic [1:0]  SDtoRegE;
    logic        MemWriteE;
    logic [31:0] ALUOutE;
    logic [31:0] WriteDataE;
    logic [4:0]  WriteRegE;
    logic [31:0] PCE;
    logic        RegWriteM;
    logic [1:0]  SDtoRegM;
    logic [31:0] ALUOutM;
    logic [31:0] ReadDataM;
    logic [4:0]  WriteRegM;
    logic [31:0] PCM;
    logic [31:0] ResultW;

    int nCompared = 0;
    int nMismatch = 0;
    bit chkEn = 1'b0;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .SDtoRegE(SDtoRegE), .MemWriteE(MemWriteE),
        .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .PCE(PCE),
        .RegWriteM(RegWriteM), .SDtoRegM(SDtoRegM), .ALUOutM(ALUOutM),
        .ReadDataM(ReadDataM), .WriteRegM(WriteRegM), .PCM(PCM), .ResultW(ResultW)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int unsigned mdlMem [1024];
    int unsigned mRegWrite, mSd, mAlu, mRead, mWreg, mPc;

    initial begin
        foreach (mdlMem[i]) mdlMem[i] = 0;
        {mRegWrite, mSd, mAlu, mRead, mWreg, mPc} = '0;
    end

    function automatic int unsigned wordOf(input int unsigned byteAddr);
        return (byteAddr % 4096) / 4;
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            foreach (mdlMem[i]) mdlMem[i] = 0;
            {mRegWrite, mSd, mAlu, mRead, mWreg, mPc} = '0;
        end else begin
            if (MemWriteE) mdlMem[wordOf(ALUOutE)] = WriteDataE;
            mRead     = mdlMem[wordOf(ALUOutE)];
            mRegWrite = RegWriteE;
            mSd       = SDtoRegE;
            mAlu      = ALUOutE;
            mWreg     = WriteRegE;
            mPc       = PCE;
        end
    end

    function automatic int unsigned mdlResult();
        if (mSd == 0) return mAlu;
        if (mSd == 1) return mRead;
        if (mSd == 2) return mPc + 8;   // unsigned int wraps at 32 bits
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            chk("mdl.RegWriteM", {31'b0, RegWriteM}, mRegWrite);
            chk("mdl.SDtoRegM",  {30'b0, SDtoRegM},  mSd);
            chk("mdl.ALUOutM",   ALUOutM,            mAlu);
            chk("mdl.ReadDataM", ReadDataM,          mRead);
            chk("mdl.WriteRegM", {27'b0, WriteRegM}, mWreg);
            chk("mdl.PCM",       PCM,                mPc);
            chk("mdl.ResultW",   ResultW,            mdlResult());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [1:0] sd, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input logic [31:0] pc);
        RegWriteE = rw; SDtoRegE = sd; MemWriteE = mw;
        ALUOutE = alu; WriteDataE = wd; WriteRegE = wr; PCE = pc;
        step();
    endtask

    initial begin
        reset = 1'b0;
        RegWriteE = 1'b1; SDtoRegE = 2'd1; MemWriteE = 1'b1;
        ALUOutE = 32'h0; WriteDataE = 32'hDEAD; WriteRegE = 5'd7; PCE = 32'h100;
        step();
        chkEn = 1'b1;
        step();
        // Reset state, store during reset discarded
        chk("rst.RegWriteM", {31'b0, RegWriteM}, 32'h0);
        chk("rst.SDtoRegM",  {30'b0, SDtoRegM},  32'h0);
        chk("rst.ALUOutM",   ALUOutM,            32'h0);
        chk("rst.ReadDataM", ReadDataM,          32'h0);
        chk("rst.WriteRegM", {27'b0, WriteRegM}, 32'h0);
        chk("rst.PCM",       PCM,                32'h0);
        chk("rst.ResultW",   ResultW,            32'h0);

        reset = 1'b1;
        drive(1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        chk("rst.load0", ReadDataM, 32'h0);

        // Store then load
        drive(1'b0, 2'd0, 1'b1, 32'h10, 32'h12345678, 5'd0, 32'h200);
        drive(1'b1, 2'd1, 1'b0, 32'h10, 32'h0, 5'd3, 32'h204);
        chk("ld.ReadDataM", ReadDataM, 32'h12345678);
        chk("ld.ResultW",   ResultW,   32'h12345678);

        // Write-first with misaligned address
        drive(1'b0, 2'd1, 1'b1, 32'h23, 32'hA5A5A5A5, 5'd0, 32'h208);
        chk("wf.ReadDataM", ReadDataM, 32'hA5A5A5A5);
        drive(1'b1, 2'd1, 1'b0, 32'h20, 32'h0, 5'd4, 32'h20C);
        chk("align.ReadDataM", ReadDataM, 32'hA5A5A5A5);

        // Address wrap
        drive(1'b0, 2'd0, 1'b1, 32'h1004, 32'h1, 5'd0, 32'h210);
        drive(1'b1, 2'd1, 1'b0, 32'h4, 32'h0, 5'd5, 32'h214);
        chk("wrap.ReadDataM", ReadDataM, 32'h1);

        // Back-to-back stores, last wins; an unrelated store leaves it intact
        drive(1'b0, 2'd0, 1'b1, 32'h40, 32'h11, 5'd0, 32'h218);
        drive(1'b0, 2'd0, 1'b1, 32'h40, 32'h22, 5'd0, 32'h21C);
        drive(1'b0, 2'd0, 1'b1, 32'h44, 32'h33, 5'd0, 32'h220);
        drive(1'b1, 2'd1, 1'b0, 32'h40, 32'h0, 5'd6, 32'h224);
        chk("b2b.ReadDataM", ReadDataM, 32'h22);

        // Result select
        drive(1'b1, 2'd0, 1'b0, 32'h7, 32'h0, 5'd31, 32'h3000);
        chk("sel0.ResultW",   ResultW,            32'h7);
        chk("sel0.WriteRegM", {27'b0, WriteRegM}, 32'd31);
        chk("sel0.RegWriteM", {31'b0, RegWriteM}, 32'h1);
        drive(1'b1, 2'd2, 1'b0, 32'h7, 32'h0, 5'd31, 32'h3000);
        chk("sel2.ResultW",   ResultW,            32'h3008);
        chk("sel2.WriteRegM", {27'b0, WriteRegM}, 32'd31);
        chk("sel2.RegWriteM", {31'b0, RegWriteM}, 32'h1);
        drive(1'b1, 2'd3, 1'b0, 32'h7, 32'h0, 5'd31, 32'h3000);
        chk("sel3.ResultW", ResultW, 32'h0);
        drive(1'b1, 2'd2, 1'b0, 32'h7, 32'h0, 5'd1, 32'hFFFFFFFC);
        chk("sel2wrap.ResultW", ResultW, 32'h4);

        // Register 0 is passed through unmasked
        drive(1'b1, 2'd0, 1'b0, 32'h9, 32'h0, 5'd0, 32'h300);
        chk("r0.RegWriteM", {31'b0, RegWriteM}, 32'h1);
        chk("r0.WriteRegM", {27'b0, WriteRegM}, 32'h0);

        // Traced store
        drive(1'b0, 2'd0, 1'b1, 32'h8, 32'hBEEF, 5'd0, 32'h3004);
        drive(1'b1, 2'd1, 1'b0, 32'h8, 32'h0, 5'd2, 32'h3008);
        chk("trace.ReadDataM", ReadDataM, 32'hBEEF);

        // Mixed traffic over a small address window, model-checked every cycle
        for (int n = 0; n < 300; n++) begin
            reset = (n == 150) ? 1'b0 : 1'b1;
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  {$urandom_range(0, 3) == 0 ? 20'h00001 : 20'h0, 12'($urandom_range(0, 63))},
                  $urandom, 5'($urandom_range(0, 31)), $urandom);
        end
        reset = 1'b1;

        // Memory cleared by the mid-run reset only where nothing was stored since
        drive(1'b0, 2'd1, 1'b0, 32'hFFC, 32'h0, 5'd0, 32'h0);
        chk("post.ReadDataM", ReadDataM, 32'h0);

        chkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and write-back front end of the 5-stage MIPS pipeline; consumes the E-stage register outputs (RegWriteE, SDtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE).
- Holds the word-addressed data memory.
- Registers the M-stage pipeline values.
- Produces the forwarding sources WriteRegM, RegWriteM and ResultW that the execute stage reads.

Parameters:
- DM_WORDS, 1024, number of 32-bit words in data memory.
- DM_AW, 10, word-address width; must equal log2(DM_WORDS).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- RegWriteE  in  1  register-write enable from E stage.
- SDtoRegE  in  2  result select from E stage.
- MemWriteE  in  1  store enable from E stage.
- ALUOutE  in  32  byte address for memory, or ALU result.
- WriteDataE  in  32  store data, already forwarded.
- WriteRegE  in  5  destination register.
- PCE  in  32  PC of the instruction in E.
- RegWriteM  out  1  registered RegWriteE.
- SDtoRegM  out  2  registered SDtoRegE.
- ALUOutM  out  32  registered ALUOutE.
- ReadDataM  out  32  registered memory read data.
- WriteRegM  out  5  registered WriteRegE.
- PCM  out  32  registered PCE.
- ResultW  out  32  combinational write-back value.

Behaviour:
- Reset (reset==0 at a rising edge):
  - RegWriteM, SDtoRegM, ALUOutM, ReadDataM, WriteRegM, PCM all become 0.
  - Every data-memory word becomes 0.
  - A MemWriteE=1 present in that cycle is discarded.
- Power-up initial values are also 0.
- Word index: idx = ALUOutE[DM_AW+1:2].
  - ALUOutE[1:0] is ignored, so misaligned addresses round down.
  - Bits above DM_AW+1 are ignored, so addresses wrap modulo DM_WORDS*4.
- Store: at a rising edge with reset==1 and MemWriteE==1, mem[idx] <= WriteDataE. Single-cycle, no handshake, no stall.
- Load: at every rising edge with reset==1, ReadDataM <= mem[idx]. The load is unconditional, with latency 1 cycle.
- Same-cycle store and load to the same idx is write-first: ReadDataM gets WriteDataE.
- Pipeline registers: at every rising edge with reset==1, each xM <= xE. No enable and no flush; bubbles arrive as RegWriteE=0/MemWriteE=0 from upstream.
- ResultW is purely combinational from the M registers:
  - SDtoRegM=0: ALUOutM
  - SDtoRegM=1: ReadDataM
  - SDtoRegM=2: PCM+8 (jal link, 32-bit wrap)
  - SDtoRegM=3: 32'h0
- WriteRegM and RegWriteM are driven unmodified from the registers. The consumer suppresses forwarding for register 0, so this block must not mask it.
- Back-to-back stores to the same idx: the last store wins.
- A load immediately after a store to the same idx, one cycle later, returns the stored value.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: on each accepted store (reset==1, MemWriteE==1), print via $display one line at the rising edge, in the format "%d@%h: *%h <= %h". The fields are $time, PCE, byte address {ALUOutE[31:2],2'b00}, and WriteDataE.
- Nothing is printed for stores suppressed by reset.
- Not defined: no display statements; functionality is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with MemWriteE=1, ALUOutE=0, WriteDataE=32'hDEAD → all outputs 0; a subsequent load of address 0 returns 0.
- Store/load: store 32'h12345678 at ALUOutE=32'h0000_0010; next cycle load 32'h10 with SDtoRegE=1 → ReadDataM=32'h12345678 and ResultW=32'h12345678.
- Write-first and alignment: same cycle MemWriteE=1, ALUOutE=32'h0000_0023, WriteDataE=32'hA5A5A5A5 → ReadDataM=32'hA5A5A5A5; a later load of 32'h20 returns 32'hA5A5A5A5.
- Wrap: store 32'h1 at ALUOutE=32'h0000_1004 (DM_AW=10) → a load of 32'h4 returns 32'h1.
- Result select: ALUOutE=32'h7, PCE=32'h0000_3000, RegWriteE=1, WriteRegE=31.
  - SDtoRegE=0 → ResultW=32'h7.
  - SDtoRegE=2 → ResultW=32'h0000_3008.
  - In both cases WriteRegM=31 and RegWriteM=1 one cycle later.
- Trace (DM_TRACE_EN defined): store 32'hBEEF at 32'h8 with PCE=32'h3004 → exactly one line containing "@00003004: *00000008 <= 0000beef"; no line for a store issued during reset.
